// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit scan frames,
// folds E0/F0 prefixes into flags and queues {ext, brk, code} events in a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic                          valid,
    output logic [7:0]                    code,
    output logic                          ext,
    output logic                          brk,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } entry_t;

    logic [2:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [10:0] shreg_q, shreg_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        ext_pend_q, ext_pend_d;
    logic        brk_pend_q, brk_pend_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic        valid_q, valid_d;
    entry_t      head_q, head_d;
    logic        overflow_q, overflow_d;
    logic        frame_err_q, frame_err_d;

    entry_t      mem_q [FIFO_DEPTH];

    logic        strobe_c;
    logic        bit_c;
    logic [10:0] frame_c;
    logic        good_c;
    logic        push_c;
    logic        pop_c;
    logic        full_c;
    logic        wr_c;
    logic [CW-1:0] remain_c;
    entry_t      wdata_c;

    // Frame receiver: synchronisers, bit counter, shift register, prefix flags, timeout
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;

        strobe_c = clk_sync_q[2] & ~clk_sync_q[1];
        bit_c    = dat_sync_q[1];
        frame_c  = {bit_c, shreg_q[10:1]};
        good_c   = ~frame_c[0] & frame_c[10] & (^frame_c[9:1]);
        wdata_c  = '{ext: ext_pend_q, brk: brk_pend_q, code: frame_c[8:1]};

        if (strobe_c) begin
            tmo_d = '0;
            if (bitcnt_q == 4'd10) begin
                bitcnt_d = 4'd0;
                if (good_c) begin
                    if (frame_c[8:1] == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (frame_c[8:1] == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        push_c     = 1'b1;
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
                shreg_d  = frame_c;
            end
        end else if (bitcnt_q != 4'd0) begin
            // A stalled partial frame is abandoned after TIMEOUT_CYCLES idle cycles
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d       = '0;
                bitcnt_d    = 4'd0;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Show-ahead FIFO: head register is precomputed so outputs stay registered
    always_comb begin
        overflow_d = overflow_q;
        pop_c      = rd_en & valid_q;
        full_c     = (count_q == CW'(FIFO_DEPTH));
        wr_c       = push_c & (~full_c | pop_c);
        if (push_c & full_c & ~pop_c) begin
            overflow_d = 1'b1;
        end
        wptr_d   = wptr_q + AW'(wr_c);
        rptr_d   = rptr_q + AW'(pop_c);
        count_d  = count_q + CW'(wr_c) - CW'(pop_c);
        remain_c = count_q - CW'(pop_c);
        valid_d  = (count_d != '0);
        if (count_d == '0) begin
            head_d = '0;
        end else if (remain_c == '0) begin
            head_d = wdata_c;
        end else begin
            head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '0;
            dat_sync_q  <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wptr_q] <= wdata_c;
        end
    end

    assign valid     = valid_q;
    assign code      = head_q.code;
    assign ext       = head_q.ext;
    assign brk       = head_q.brk;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed table, multi-cycle corner sequences and
// randomized frames checked against a queue-based keyboard event model.
module tb_ps2_kbd_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;
    localparam int          H     = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       valid;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .valid(valid), .code(code), .ext(ext), .brk(brk), .count(count),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int err_seen = 0;
    int exp_err = 0;

    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    // Reference model: pending prefixes, event queue, sticky overflow
    logic [9:0] mq[$];
    bit m_ext, m_brk, m_ovf;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad);
        if (bad) begin
            exp_err++;
            m_ext = 0; m_brk = 0;
        end else if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else begin
            if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, d});
            else m_ovf = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_pop();
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic check_model(input string tag);
        logic [9:0] h;
        h = (mq.size() != 0) ? mq[0] : 10'd0;
        chk({tag, ".valid"}, int'(valid), int'(mq.size() != 0));
        chk({tag, ".code"}, int'(code), int'(h[7:0]));
        chk({tag, ".ext"}, int'(ext), int'(h[9]));
        chk({tag, ".brk"}, int'(brk), int'(h[8]));
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".frame_err_pulses"}, err_seen, exp_err);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad);
        logic par;
        par = ~(^d) ^ bad;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Drive nbits of a frame LSB first; optionally pulse rd_en on the edge the frame completes
    task automatic send_raw(input logic [10:0] f, input int nbits, input bit pop_last);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_last && i == 10) begin
                repeat (2) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (H - 3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad, input bit pop_last);
        send_raw(mk_frame(d, bad), 11, pop_last);
        if (pop_last) model_pop();
        model_frame(d, bad);
    endtask

    task automatic do_pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        model_pop();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("rst.valid", int'(valid), 0);
        chk("rst.code", int'(code), 0);
        chk("rst.ext_brk", int'({ext, brk}), 0);
        chk("rst.count", int'(count), 0);
        chk("rst.overflow", int'(overflow), 0);
        chk("rst.frame_err", int'(frame_err), 0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        bit         send;
        logic [7:0] data;
        bit         bad;
        bit         pop;
        bit         e_valid;
        logic [7:0] e_code;
        bit         e_ext;
        bit         e_brk;
        int         e_count;
        int         e_err_inc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int base;
        logic [7:0] d;
        bit bad;

        vecs[0]  = '{1, 8'h1C, 0, 0, 1, 8'h1C, 0, 0, 1, 0};
        vecs[1]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vecs[3]  = '{1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[4]  = '{1, 8'h1C, 0, 0, 1, 8'h1C, 0, 1, 1, 0};
        vecs[5]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vecs[6]  = '{1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[7]  = '{1, 8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[8]  = '{1, 8'h75, 0, 0, 1, 8'h75, 1, 1, 1, 0};
        vecs[9]  = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vecs[10] = '{1, 8'h1C, 1, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[11] = '{1, 8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vecs[12] = '{1, 8'h33, 1, 0, 0, 8'h00, 0, 0, 0, 1};
        vecs[13] = '{1, 8'h2D, 0, 0, 1, 8'h2D, 0, 0, 1, 0};
        vecs[14] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0};

        model_reset();
        #23;
        chk("por.valid", int'(valid), 0);
        chk("por.count", int'(count), 0);
        chk("por.code", int'(code), 0);
        chk("por.overflow", int'(overflow), 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            base = err_seen;
            if (vecs[i].send) send_frame(vecs[i].data, vecs[i].bad, 0);
            if (vecs[i].pop) do_pop();
            chk($sformatf("vec%0d.valid", i), int'(valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d.code", i), int'(code), int'(vecs[i].e_code));
            chk($sformatf("vec%0d.ext", i), int'(ext), int'(vecs[i].e_ext));
            chk($sformatf("vec%0d.brk", i), int'(brk), int'(vecs[i].e_brk));
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d.err_inc", i), err_seen - base, vecs[i].e_err_inc);
        end
        check_model("after_table");

        // Overflow: nine makes with no reads
        do_reset();
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0);
        chk("ovf.count", int'(count), 8);
        chk("ovf.flag", int'(overflow), 1);
        chk("ovf.head", int'(code), 8'h10);
        check_model("ovf");

        // Full FIFO with pop on the completing edge of a tenth frame
        send_frame(8'h42, 0, 1);
        chk("fullpp.count", int'(count), 8);
        chk("fullpp.flag", int'(overflow), 1);
        chk("fullpp.head", int'(code), 8'h11);
        check_model("fullpp");
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("fullpp.tail", int'(code), 8'h42);
            do_pop();
            check_model($sformatf("drain%0d", i));
        end

        // Reset mid-frame clears everything immediately and restarts reception
        send_frame(8'h1C, 0, 0);
        send_raw(mk_frame(8'h5A, 0), 5, 0);
        do_reset();
        send_frame(8'h2D, 0, 0);
        chk("midrst.code", int'(code), 8'h2D);
        chk("midrst.count", int'(count), 1);
        check_model("midrst");
        do_pop();

        // Timeout on a partial frame, then a clean frame
        base = err_seen;
        send_raw(mk_frame(8'h2D, 0), 5, 0);
        repeat (TMO + 40) @(negedge clk);
        exp_err++;
        chk("tmo.err_inc", err_seen - base, 1);
        chk("tmo.count", int'(count), 0);
        send_frame(8'h2D, 0, 0);
        chk("tmo.code", int'(code), 8'h2D);
        chk("tmo.valid", int'(valid), 1);
        check_model("tmo");

        // Randomized frames against the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: d = 8'hE0;
                1: d = 8'hF0;
                default: begin
                    d = 8'($urandom_range(0, 255));
                    if (d == 8'hE0 || d == 8'hF0) d = d ^ 8'h01;
                end
            endcase
            bad = ($urandom_range(0, 7) == 0);
            send_frame(d, bad, $urandom_range(0, 5) == 0);
            check_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) begin
                do_pop();
                check_model($sformatf("rndpop%0d", i));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
